// File: rtl/decode_stage.sv
// RV32I decode stage: decodes instr_in into ALU-facing fields and queues the
// results in a 2-entry skid buffer with valid/ready handshakes on both sides.
package decode_pkg;

  localparam logic [5:0] INSTR_INVALID = 6'd0;
  localparam logic [5:0] INSTR_LUI     = 6'd1;
  localparam logic [5:0] INSTR_AUIPC   = 6'd2;
  localparam logic [5:0] INSTR_JAL     = 6'd3;
  localparam logic [5:0] INSTR_JALR    = 6'd4;
  localparam logic [5:0] INSTR_BEQ     = 6'd5;
  localparam logic [5:0] INSTR_BNE     = 6'd6;
  localparam logic [5:0] INSTR_BLT     = 6'd7;
  localparam logic [5:0] INSTR_BGE     = 6'd8;
  localparam logic [5:0] INSTR_BLTU    = 6'd9;
  localparam logic [5:0] INSTR_BGEU    = 6'd10;
  localparam logic [5:0] INSTR_LB      = 6'd11;
  localparam logic [5:0] INSTR_LH      = 6'd12;
  localparam logic [5:0] INSTR_LW      = 6'd13;
  localparam logic [5:0] INSTR_LBU     = 6'd14;
  localparam logic [5:0] INSTR_LHU     = 6'd15;
  localparam logic [5:0] INSTR_SB      = 6'd16;
  localparam logic [5:0] INSTR_SH      = 6'd17;
  localparam logic [5:0] INSTR_SW      = 6'd18;
  localparam logic [5:0] INSTR_ADDI    = 6'd19;
  localparam logic [5:0] INSTR_SLTI    = 6'd20;
  localparam logic [5:0] INSTR_SLTIU   = 6'd21;
  localparam logic [5:0] INSTR_XORI    = 6'd22;
  localparam logic [5:0] INSTR_ORI     = 6'd23;
  localparam logic [5:0] INSTR_ANDI    = 6'd24;
  localparam logic [5:0] INSTR_SLLI    = 6'd25;
  localparam logic [5:0] INSTR_SRLI    = 6'd26;
  localparam logic [5:0] INSTR_SRAI    = 6'd27;
  localparam logic [5:0] INSTR_ADD     = 6'd28;
  localparam logic [5:0] INSTR_SUB     = 6'd29;
  localparam logic [5:0] INSTR_SLL     = 6'd30;
  localparam logic [5:0] INSTR_SLT     = 6'd31;
  localparam logic [5:0] INSTR_SLTU    = 6'd32;
  localparam logic [5:0] INSTR_XOR     = 6'd33;
  localparam logic [5:0] INSTR_SRL     = 6'd34;
  localparam logic [5:0] INSTR_SRA     = 6'd35;
  localparam logic [5:0] INSTR_OR      = 6'd36;
  localparam logic [5:0] INSTR_AND     = 6'd37;

  typedef struct packed {
    logic [5:0]  id;
    logic [31:0] imm;
    logic [4:0]  rs1;
    logic [4:0]  rs2;
    logic [4:0]  rd;
    logic [31:0] pc;
    logic        illegal;
  } dec_entry_t;

  typedef enum logic [2:0] {FMT_R, FMT_I, FMT_SH, FMT_S, FMT_B, FMT_U, FMT_J} fmt_e;

endpackage

module decode_stage
  import decode_pkg::*;
#(
  parameter int XLEN       = 32,
  parameter int SKID_DEPTH = 2
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic [XLEN-1:0] instr_in,
  input  logic [XLEN-1:0] pc_in,
  input  logic            flush,
  output logic            out_valid,
  input  logic            out_ready,
  output logic [5:0]      instr_id,
  output logic [XLEN-1:0] imm,
  output logic [4:0]      rs1_addr,
  output logic [4:0]      rs2_addr,
  output logic [4:0]      rd_addr,
  output logic [XLEN-1:0] pc_out,
  output logic            illegal
);

  typedef enum logic [1:0] {EMPTY = 2'd0, ONE = 2'd1, FULL = 2'(SKID_DEPTH)} count_e;

  function automatic dec_entry_t decode(input logic [31:0] i, input logic [31:0] pc);
    dec_entry_t e;
    fmt_e       fmt;
    logic [5:0] id;
    logic [6:0] f7;
    logic [2:0] f3;
    f7  = i[31:25];
    f3  = i[14:12];
    id  = INSTR_INVALID;
    fmt = FMT_R;
    case (i[6:0])
      7'b0110111: begin id = INSTR_LUI;   fmt = FMT_U; end
      7'b0010111: begin id = INSTR_AUIPC; fmt = FMT_U; end
      7'b1101111: begin id = INSTR_JAL;   fmt = FMT_J; end
      7'b1100111: begin
        fmt = FMT_I;
        id  = (f3 == 3'd0) ? INSTR_JALR : INSTR_INVALID;
      end
      7'b1100011: begin
        fmt = FMT_B;
        case (f3)
          3'd0:    id = INSTR_BEQ;
          3'd1:    id = INSTR_BNE;
          3'd4:    id = INSTR_BLT;
          3'd5:    id = INSTR_BGE;
          3'd6:    id = INSTR_BLTU;
          3'd7:    id = INSTR_BGEU;
          default: id = INSTR_INVALID;
        endcase
      end
      7'b0000011: begin
        fmt = FMT_I;
        case (f3)
          3'd0:    id = INSTR_LB;
          3'd1:    id = INSTR_LH;
          3'd2:    id = INSTR_LW;
          3'd4:    id = INSTR_LBU;
          3'd5:    id = INSTR_LHU;
          default: id = INSTR_INVALID;
        endcase
      end
      7'b0100011: begin
        fmt = FMT_S;
        case (f3)
          3'd0:    id = INSTR_SB;
          3'd1:    id = INSTR_SH;
          3'd2:    id = INSTR_SW;
          default: id = INSTR_INVALID;
        endcase
      end
      7'b0010011: begin
        fmt = FMT_I;
        case (f3)
          3'd0: id = INSTR_ADDI;
          3'd2: id = INSTR_SLTI;
          3'd3: id = INSTR_SLTIU;
          3'd4: id = INSTR_XORI;
          3'd6: id = INSTR_ORI;
          3'd7: id = INSTR_ANDI;
          3'd1: begin
            fmt = FMT_SH;
            id  = (f7 == 7'b0000000) ? INSTR_SLLI : INSTR_INVALID;
          end
          3'd5: begin
            fmt = FMT_SH;
            if (f7 == 7'b0000000)      id = INSTR_SRLI;
            else if (f7 == 7'b0100000) id = INSTR_SRAI;
            else                       id = INSTR_INVALID;
          end
          default: id = INSTR_INVALID;
        endcase
      end
      7'b0110011: begin
        fmt = FMT_R;
        case ({f7, f3})
          10'b0000000_000: id = INSTR_ADD;
          10'b0100000_000: id = INSTR_SUB;
          10'b0000000_001: id = INSTR_SLL;
          10'b0000000_010: id = INSTR_SLT;
          10'b0000000_011: id = INSTR_SLTU;
          10'b0000000_100: id = INSTR_XOR;
          10'b0000000_101: id = INSTR_SRL;
          10'b0100000_101: id = INSTR_SRA;
          10'b0000000_110: id = INSTR_OR;
          10'b0000000_111: id = INSTR_AND;
          default:         id = INSTR_INVALID;
        endcase
      end
      default: id = INSTR_INVALID;
    endcase

    // Illegal entries keep only their pc so they still flow through the handshake.
    e    = '0;
    e.pc = pc;
    if (id == INSTR_INVALID) begin
      e.illegal = 1'b1;
    end else begin
      e.id = id;
      case (fmt)
        FMT_R: begin
          e.rs1 = i[19:15]; e.rs2 = i[24:20]; e.rd = i[11:7];
        end
        FMT_I: begin
          e.imm = {{20{i[31]}}, i[31:20]};
          e.rs1 = i[19:15]; e.rd = i[11:7];
        end
        FMT_SH: begin
          e.imm = {27'b0, i[24:20]};
          e.rs1 = i[19:15]; e.rd = i[11:7];
        end
        FMT_S: begin
          e.imm = {{20{i[31]}}, i[31:25], i[11:7]};
          e.rs1 = i[19:15]; e.rs2 = i[24:20];
        end
        FMT_B: begin
          e.imm = {{19{i[31]}}, i[31], i[7], i[30:25], i[11:8], 1'b0};
          e.rs1 = i[19:15]; e.rs2 = i[24:20];
        end
        FMT_U: begin
          e.imm = {i[31:12], 12'b0};
          e.rd  = i[11:7];
        end
        FMT_J: begin
          e.imm = {{11{i[31]}}, i[31], i[19:12], i[20], i[30:21], 1'b0};
          e.rd  = i[11:7];
        end
        default: begin
          e.id      = INSTR_INVALID;
          e.illegal = 1'b1;
        end
      endcase
    end
    return e;
  endfunction

  count_e     count_q;
  dec_entry_t slot0_q, slot1_q;
  logic       out_valid_q, in_ready_q;
  dec_entry_t dec_d;
  logic       push, pop;

  assign dec_d = decode(instr_in, pc_in);
  assign push  = in_valid & in_ready_q;
  assign pop   = out_valid_q & out_ready;

  // Occupancy FSM; slot0 is always the head so outputs come straight from it.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count_q     <= EMPTY;
      slot0_q     <= '0;
      slot1_q     <= '0;
      out_valid_q <= 1'b0;
      in_ready_q  <= 1'b1;
    end else if (flush) begin
      count_q     <= EMPTY;
      out_valid_q <= 1'b0;
      in_ready_q  <= 1'b1;
    end else begin
      case (count_q)
        EMPTY: begin
          if (push) begin
            slot0_q     <= dec_d;
            count_q     <= ONE;
            out_valid_q <= 1'b1;
          end
        end
        ONE: begin
          if (push && pop) begin
            slot0_q <= dec_d;
          end else if (push) begin
            slot1_q    <= dec_d;
            count_q    <= FULL;
            in_ready_q <= 1'b0;
          end else if (pop) begin
            count_q     <= EMPTY;
            out_valid_q <= 1'b0;
          end
        end
        FULL: begin
          if (pop) begin
            slot0_q    <= slot1_q;
            count_q    <= ONE;
            in_ready_q <= 1'b1;
          end
        end
        default: begin
          count_q     <= EMPTY;
          out_valid_q <= 1'b0;
          in_ready_q  <= 1'b1;
        end
      endcase
    end
  end

  assign in_ready  = in_ready_q;
  assign out_valid = out_valid_q;
  assign instr_id  = slot0_q.id;
  assign imm       = slot0_q.imm;
  assign rs1_addr  = slot0_q.rs1;
  assign rs2_addr  = slot0_q.rs2;
  assign rd_addr   = slot0_q.rd;
  assign pc_out    = slot0_q.pc;
  assign illegal   = slot0_q.illegal;

endmodule
